lab8_soc_sysid_checker: RTL
===========================

LAB8_SOC_SYSID_CHECKER -- requirements
Module: lab8_soc_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0, system ID value the slave SHALL return at word address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'd1476564658, build timestamp the slave SHALL return at word address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max cycles per transfer (request plus data wait) before abort.
REQ-004 Parameter AUTO_START, default 1, check launches automatically after reset release.
REQ-005 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-006 clock  input  1  rising-edge system clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse launches a check.
REQ-009 avm_address  output  1  word address to sysid slave (0 = ID, 1 = timestamp).
REQ-010 avm_read  output  1  Avalon-MM read request.
REQ-011 avm_waitrequest  input  1  slave stall; request accepted on cycle with avm_read=1 and avm_waitrequest=0.
REQ-012 avm_readdata  input  32  read data.
REQ-013 avm_readdatavalid  input  1  avm_readdata valid this cycle.
REQ-014 busy  output  1  check in progress.
REQ-015 done  output  1  level; check finished (normal or timeout).
REQ-016 id_match, ts_match  output  1 each  captured word equals expected parameter.
REQ-017 timeout  output  1  check aborted by timeout.
REQ-018 id_value, ts_value  output  32 each  captured words.

Function
REQ-019 FSM states SHALL be IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE.
REQ-020 IDLE/DONE -> REQ_ID on start=1 (or first cycle after reset when AUTO_START=1); entering REQ_ID clears done, timeout, id_match, ts_match, id_value, ts_value.
REQ-021 In REQ_ID, avm_read=1, avm_address=0, both held stable until acceptance; on acceptance -> WAIT_ID, or -> REQ_TS directly if avm_readdatavalid=1 in the same cycle (zero-latency slave).
REQ-022 In WAIT_ID, avm_read=0; on avm_readdatavalid=1 capture avm_readdata into id_value, -> REQ_TS.
REQ-023 REQ_TS/WAIT_TS SHALL mirror REQ-021/022 with avm_address=1, capturing into ts_value, ending in DONE.
REQ-024 On entering DONE: done=1, id_match=(id_value==EXPECTED_ID), ts_match=(ts_value==EXPECTED_TIMESTAMP), registered, valid the cycle done rises.
REQ-025 Only one outstanding read at any time; avm_read SHALL be 0 in IDLE, WAIT_*, DONE.
REQ-026 busy=1 in REQ_* and WAIT_* states, else 0.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 avm_readdatavalid in IDLE, DONE or REQ_* without acceptance SHALL be ignored.
REQ-029 8-bit-min timeout counter reset on entering each REQ_* state, increments each cycle in REQ_*/WAIT_*; reaching TIMEOUT_CYCLES -> DONE with timeout=1, id_match=0, ts_match=0, avm_read deasserted same transition.
REQ-030 Unused avm_address in IDLE/DONE SHALL be 0.

Reset
REQ-031 While reset_n=0: state IDLE, avm_read=0, avm_address=0, busy=0, done=0, timeout=0, id_match=0, ts_match=0, id_value=0, ts_value=0, timeout counter 0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately; no capture; restart only per REQ-020 after release.

Verification
REQ-033 Zero-latency slave (waitrequest=0, readdatavalid same cycle, data 0 then 1476564658), AUTO_START=1 -> done=1 on 3rd cycle after reset release, id_match=1, ts_match=1, timeout=0.
REQ-034 waitrequest held 1 for 5 cycles, readdatavalid 2 cycles after accept -> avm_read/avm_address stable throughout stall, values captured, id_match=ts_match=1.
REQ-035 Timestamp returns 32'h12345678 -> done=1, id_match=1, ts_match=0, ts_value=32'h12345678.
REQ-036 waitrequest stuck 1, TIMEOUT_CYCLES=16 -> timeout=1, done=1 after 16 cycles in REQ_ID, avm_read=0 thereafter.
REQ-037 start pulsed during busy, then after done -> first ignored, second clears results and reruns check; reset_n dropped during WAIT_TS -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lab8_soc_sysid_checker.sv
// rtl/lab8_soc_sysid_checker.sv - reads sysid ID and timestamp words over Avalon-MM and compares them to expected values
module lab8_soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1476564658,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (CLOG > 8) ? CLOG : 8;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            auto_pend;
  logic            accept, tmo_hit;
  logic            launch, cap_id, cap_ts, to_hit;

  assign avm_read    = (state == S_REQ_ID) || (state == S_REQ_TS);
  assign avm_address = (state == S_REQ_TS);
  assign busy        = (state == S_REQ_ID) || (state == S_WAIT_ID) ||
                       (state == S_REQ_TS) || (state == S_WAIT_TS);
  assign accept      = avm_read && !avm_waitrequest;
  assign tmo_hit     = (cnt == TMO_LAST);

  // Acceptance and data arrival take priority over a timeout landing on the same cycle.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start || auto_pend) begin
          state_nxt = S_REQ_ID;
          launch    = 1'b1;
        end
      end
      S_REQ_ID: begin
        if (accept) begin
          if (avm_readdatavalid) begin
            cap_id    = 1'b1;
            state_nxt = S_REQ_TS;
          end else begin
            state_nxt = S_WAIT_ID;
          end
        end else if (tmo_hit) begin
          to_hit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT_ID: begin
        if (avm_readdatavalid) begin
          cap_id    = 1'b1;
          state_nxt = S_REQ_TS;
        end else if (tmo_hit) begin
          to_hit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_REQ_TS: begin
        if (accept) begin
          if (avm_readdatavalid) begin
            cap_ts    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT_TS;
          end
        end else if (tmo_hit) begin
          to_hit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT_TS: begin
        if (avm_readdatavalid) begin
          cap_ts    = 1'b1;
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          to_hit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      auto_pend <= AUTO_START;
    end else begin
      state     <= state_nxt;
      auto_pend <= 1'b0;
    end
  end

  // Budget covers request plus data wait, so it restarts only when a new request begins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if ((state_nxt != state) &&
                 ((state_nxt == S_REQ_ID) || (state_nxt == S_REQ_TS))) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The timestamp compare uses the bus word directly so a zero-latency capture is still correct.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done     <= 1'b0;
      timeout  <= 1'b0;
      id_match <= 1'b0;
      ts_match <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else if (launch) begin
      done     <= 1'b0;
      timeout  <= 1'b0;
      id_match <= 1'b0;
      ts_match <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (cap_id) begin
        id_value <= avm_readdata;
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        done     <= 1'b1;
        id_match <= (id_value == EXPECTED_ID);
        ts_match <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (to_hit) begin
        done     <= 1'b1;
        timeout  <= 1'b1;
        id_match <= 1'b0;
        ts_match <= 1'b0;
      end
    end
  end

endmodule
